frame_buffer: RTL and testbench

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer.sv | 156 +++++++++++++++
 tb/tb_frame_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// Ping-pong frame buffer between the header detector and the FFT stage.
// Collects exactly FRAME_LEN-sample runs into two banks and streams them out in arrival order.
module frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_err,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DISCARD
    } wr_state_t;

    logic [DATA_W-1:0] bank [2][FRAME_LEN];
    logic [1:0]        full_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [IDX_W-1:0]  rd_idx_q;

    wr_state_t        state_q;
    wr_state_t        state_d;
    logic [IDX_W-1:0] wr_idx_d;
    logic             armed_q;
    logic             armed_d;
    logic             wr_en;
    logic             frame_done;
    logic             drop;
    logic             err_d;
    logic             accept;
    logic             rd_done;

    // armed_q: a frame just completed, so the next sample of the same run is an over-long error.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        armed_d    = armed_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!full_q[wr_ptr_q]) begin
                        wr_en    = 1'b1;
                        wr_idx_d = IDX_W'(1);
                        state_d  = FILL;
                    end else begin
                        drop    = 1'b1;
                        armed_d = 1'b0;
                        state_d = DISCARD;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        wr_idx_d   = '0;
                        armed_d    = 1'b1;
                        state_d    = DISCARD;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end else begin
                    wr_idx_d = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            DISCARD: begin
                if (in_valid) begin
                    if (armed_q) begin
                        err_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    armed_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = full_q[rd_ptr_q];
    assign out_data  = out_valid ? bank[rd_ptr_q][rd_idx_q] : '0;
    assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
    assign accept    = out_valid && out_ready;
    assign rd_done   = accept && (rd_idx_q == LAST_IDX);

    // NOTE: sample storage is plain RAM with no reset; out_data is masked while out_valid is low instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wr_ptr_q][wr_idx_q] <= in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            armed_q   <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rd_idx_q  <= '0;
            full_q    <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            armed_q   <= armed_d;
            frame_err <= err_d;
            if (frame_done) begin
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            // The bank being read is always the other bank from the one being completed.
            if (rd_done) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
                rd_idx_q         <= '0;
            end else if (accept) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: the driver models whole runs/frames, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_frame_buffer;

    localparam int FL = 10;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        frame_err;
    logic        overflow;
    logic [7:0]  drop_cnt;

    frame_buffer #(.DATA_W(16), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_err (frame_err),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: frames completed (driver-owned) and frames fully delivered (monitor-owned).
    beat_t       exp_q[$];
    int          completed = 0;
    int          delivered = 0;
    logic        exp_err = 1'b0;
    logic        exp_overflow = 1'b0;
    int          exp_drop_cnt = 0;

    logic        run_active = 1'b0;
    logic        run_dropped = 1'b0;
    int          run_len = 0;
    logic [15:0] run_samples[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle (called at posedge+1), then fold the effects of that edge into the model.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        logic pend_err, pend_complete, pend_drop;
        pend_err = 1'b0;
        pend_complete = 1'b0;
        pend_drop = 1'b0;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (v) begin
            if (!run_active) begin
                run_active  = 1'b1;
                run_len     = 0;
                run_samples.delete();
                run_dropped = ((completed - delivered) == 2);
                pend_drop   = run_dropped;
            end
            run_len++;
            if (!run_dropped) begin
                if (run_len <= FL) run_samples.push_back(d);
                if (run_len == FL) pend_complete = 1'b1;
                if (run_len == FL + 1) pend_err = 1'b1;
            end
        end else if (run_active) begin
            run_active = 1'b0;
            if (!run_dropped && run_len < FL) pend_err = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_err = pend_err;
        if (pend_drop) begin
            exp_overflow = 1'b1;
            if (exp_drop_cnt < 255) exp_drop_cnt++;
        end
        if (pend_complete) begin
            for (int i = 0; i < FL; i++) begin
                beat_t b;
                b.last = (i == FL - 1);
                b.data = run_samples[i];
                exp_q.push_back(b);
            end
            completed++;
        end
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, pick_ready(rdy_mode));
    endtask

    task automatic run(input int len, input int gap, input int rdy_mode, input logic [15:0] base);
        for (int i = 0; i < len; i++) step(1'b1, base + 16'(i), pick_ready(rdy_mode));
        idle(gap, rdy_mode);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        exp_q.delete();
        completed    = delivered;
        exp_err      = 1'b0;
        exp_overflow = 1'b0;
        exp_drop_cnt = 0;
        run_active   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle away from the active edge.
    initial begin : monitor
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        beat_t       b;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            check("out_valid", 32'(out_valid), 32'((completed - delivered) > 0));
            check("frame_err", 32'(frame_err), 32'(exp_err));
            check("overflow", 32'(overflow), 32'(exp_overflow));
            check("drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt));
            if (!out_valid) check("idle_data_zero", 32'(out_data), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", out_data, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_last", 32'(out_last), 32'(b.last));
                    if (b.last) delivered++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin : driver
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_out_last", 32'(out_last), 32'd0);
        check("init_frame_err", 32'(frame_err), 32'd0);
        check("init_overflow", 32'(overflow), 32'd0);
        check("init_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1);

        // Single frame 0x0001..0x000A with the consumer always ready.
        run(FL, 1, 1, 16'h0001);
        idle(12, 1);

        // Backpressure for five cycles in the middle of a frame.
        run(FL, 1, 1, 16'h0100);
        idle(3, 1);
        idle(5, 0);
        idle(12, 1);

        // Three frames with no consumer: third is dropped, then 20 beats drain.
        run(FL, 2, 0, 16'h0200);
        run(FL, 2, 0, 16'h0300);
        run(FL, 2, 0, 16'h0400);
        idle(25, 1);

        // Short run followed by a good frame.
        run(4, 2, 1, 16'h0500);
        run(FL, 2, 1, 16'h0600);
        idle(12, 1);

        // Over-long run: first ten kept, one error on sample eleven.
        run(12, 2, 1, 16'h0700);
        idle(12, 1);

        // Random runs of all lengths against a random consumer.
        for (int k = 0; k < 40; k++) begin
            run($urandom_range(1, 13), $urandom_range(1, 3), 2, 16'($urandom));
        end
        idle(40, 1);

        // Fill both banks, then push enough dropped runs to saturate drop_cnt.
        run(FL, 1, 0, 16'h0A00);
        run(FL, 1, 0, 16'h0B00);
        for (int k = 0; k < 260; k++) run(1, 1, 0, 16'(k));
        idle(25, 1);

        // Reset in the middle of output, then a clean frame into bank 0.
        run(FL, 1, 1, 16'h0800);
        idle(3, 1);
        do_reset();
        run(FL, 1, 1, 16'h0900);

        for (int i = 0; i < 500; i++) begin
            if ((completed - delivered) == 0 && exp_q.size() == 0) break;
            step(1'b0, 16'h0, 1'b1);
        end
        check("drain_frames_left", 32'(completed - delivered), 32'd0);
        check("drain_beats_left", 32'(exp_q.size()), 32'd0);
        idle(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
